// File: rtl/lstm_sequencer_if.sv
// Sequencer-facing bundle: upstream samples, cell issue/result path, downstream results.
// The master modport is the sequencer side; slave is the environment (source, cell, sink).
interface lstm_sequencer_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] h_init;
  logic signed [WIDTH-1:0] c_init;
  logic signed [WIDTH-1:0] cell_x;
  logic signed [WIDTH-1:0] cell_h;
  logic signed [WIDTH-1:0] cell_c;
  logic                    cell_x_valid;
  logic                    cell_x_ready;
  logic signed [WIDTH-1:0] cell_y;
  logic                    cell_y_valid;
  logic signed [WIDTH-1:0] cell_c_out;
  logic signed [WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;
  logic                    err;

  modport master (
    input  s_data, s_valid, h_init, c_init, cell_x_ready, cell_y, cell_y_valid, cell_c_out, m_ready,
    output s_ready, cell_x, cell_h, cell_c, cell_x_valid, m_data, m_valid, m_last, err
  );

  modport slave (
    output s_data, s_valid, h_init, c_init, cell_x_ready, cell_y, cell_y_valid, cell_c_out, m_ready,
    input  s_ready, cell_x, cell_h, cell_c, cell_x_valid, m_data, m_valid, m_last, err
  );
endinterface

// File: rtl/lstm_sequencer.sv
// Steps one sample at a time through an external LSTM cell, carrying h/C between steps.
// Optional WAIT-state watchdog compiled in with `define LSTM_SEQ_WATCHDOG_EN.
module lstm_sequencer #(
  parameter int WIDTH   = 16,
  parameter int SEQ_LEN = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  lstm_sequencer_if.master    bus
);

  if (SEQ_LEN < 2 || SEQ_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("lstm_sequencer: SEQ_LEN must be 2..255 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
`ifdef LSTM_SEQ_WATCHDOG_EN
    OUTPUT,
    ERROR
`else
    OUTPUT
`endif
  } state_t;

  localparam logic [7:0] LAST_STEP = 8'(SEQ_LEN - 1);

  state_t                  r_state, w_next;
  logic [7:0]              r_step;
  logic signed [WIDTH-1:0] r_x, r_h, r_c, r_mdata;
  logic                    r_s_ready;
  logic                    w_accept, w_issue, w_capture, w_handshake, w_wrap;

  assign w_accept    = (r_state == IDLE) && r_s_ready && bus.s_valid;
  assign w_issue     = (r_state == ISSUE) && bus.cell_x_ready;
  assign w_capture   = (r_state == WAIT) && bus.cell_y_valid;
  assign w_handshake = (r_state == OUTPUT) && bus.m_ready;
  assign w_wrap      = w_handshake && (r_step == LAST_STEP);

`ifdef LSTM_SEQ_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] r_wd;
  logic            r_err;
  logic            w_expired;

  assign w_expired = (r_state == WAIT) && !bus.cell_y_valid && (r_wd == WD_LAST);

  // Counts idle WAIT cycles; any other state clears it, so each WAIT visit starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd  <= (r_state == WAIT) ? r_wd + WD_ONE : '0;
      r_err <= (w_next == ERROR);
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next = ISSUE;
      ISSUE:  if (w_issue) w_next = WAIT;
      WAIT: begin
        if (w_capture) w_next = OUTPUT;
`ifdef LSTM_SEQ_WATCHDOG_EN
        else if (w_expired) w_next = ERROR;
`endif
      end
      OUTPUT: if (w_handshake) w_next = IDLE;
`ifdef LSTM_SEQ_WATCHDOG_EN
      ERROR:  w_next = ERROR;
`endif
      default: w_next = IDLE;
    endcase
  end

  // s_ready is registered from the next state so it stays low throughout reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_s_ready <= (w_next == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step  <= '0;
      r_x     <= '0;
      r_h     <= '0;
      r_c     <= '0;
      r_mdata <= '0;
    end else if (w_accept) begin
      r_x <= bus.s_data;
      if (r_step == 8'd0) begin
        r_h <= bus.h_init;
        r_c <= bus.c_init;
      end
    end else if (w_capture) begin
      r_h     <= bus.cell_y;
      r_c     <= bus.cell_c_out;
      r_mdata <= bus.cell_y;
    end else if (w_wrap) begin
      r_step <= '0;
      r_h    <= bus.h_init;
      r_c    <= bus.c_init;
    end else if (w_handshake) begin
      r_step <= r_step + 8'd1;
    end
  end

  assign bus.s_ready      = r_s_ready;
  assign bus.cell_x       = r_x;
  assign bus.cell_h       = r_h;
  assign bus.cell_c       = r_c;
  assign bus.cell_x_valid = w_issue;
  assign bus.m_data       = r_mdata;
  assign bus.m_valid      = (r_state == OUTPUT);
  assign bus.m_last       = (r_state == OUTPUT) && (r_step == LAST_STEP);

endmodule

// File: tb/tb_lstm_sequencer.sv
// Self-checking bench for lstm_sequencer (SEQ_LEN=2, TIMEOUT=64) with a step-level reference model.
module tb_lstm_sequencer;
  localparam int W = 16;
  localparam int SL = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lstm_sequencer_if #(.WIDTH(W)) bus ();

  lstm_sequencer #(.WIDTH(W), .SEQ_LEN(SL), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: recurrent state after each completed step.
  logic [W-1:0] m_h, m_c;
  int           m_step;

  logic [W-1:0] oh, oc, ox, om;
  logic         olast;
  int           pulses;
  bit           stable, tmo;

  function automatic logic [W-1:0] exp_h();
    return (m_step == 0) ? bus.h_init : m_h;
  endfunction

  function automatic logic [W-1:0] exp_c();
    return (m_step == 0) ? bus.c_init : m_c;
  endfunction

  task automatic model_apply(input logic [W-1:0] y, co);
    m_h    = y;
    m_c    = co;
    m_step = (m_step + 1) % SL;
  endtask

  task automatic run_step(input logic [W-1:0] x, y, co, input int busy, lat, bp,
                          output int np, output logic [W-1:0] rh, rc, rx, rm,
                          output logic rlast, output bit rstab, output bit rtmo);
    int n;
    np = 0; rstab = 1'b1; rtmo = 1'b0;
    rh = '0; rc = '0; rx = '0; rm = '0; rlast = 1'b0;
    bus.cell_x_ready = (busy == 0);
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.s_ready !== 1'b1) begin
      rtmo = 1'b1;
      return;
    end
    bus.s_data  = x;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = W'($urandom);
    rh = bus.cell_h; rc = bus.cell_c; rx = bus.cell_x;
    for (int i = 0; i < busy; i++) begin
      if (bus.cell_x_valid === 1'b1) np++;
      @(negedge clk);
      if (bus.cell_h !== rh || bus.cell_c !== rc || bus.cell_x !== rx) rstab = 1'b0;
    end
    bus.cell_x_ready = 1'b1;
    #1;
    if (bus.cell_x_valid === 1'b1) np++;
    @(negedge clk);
    for (int i = 0; i < lat; i++) begin
      if (bus.cell_h !== rh || bus.cell_c !== rc || bus.cell_x !== rx) rstab = 1'b0;
      if (bus.cell_x_valid === 1'b1) np++;
      @(negedge clk);
    end
    if (bus.cell_h !== rh || bus.cell_c !== rc || bus.cell_x !== rx) rstab = 1'b0;
    bus.cell_y       = y;
    bus.cell_c_out   = co;
    bus.cell_y_valid = 1'b1;
    @(negedge clk);
    bus.cell_y_valid = 1'b0;
    bus.cell_c_out   = W'($urandom);
    bus.m_ready      = 1'b0;
    rm = bus.m_data; rlast = bus.m_last;
    for (int i = 0; i < bp; i++) begin
      if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_data !== rm || bus.m_last !== rlast)
        rstab = 1'b0;
      if (bus.cell_x_valid === 1'b1) np++;
      bus.cell_y_valid = (i == 1);
      bus.cell_y       = ~y;
      @(negedge clk);
    end
    bus.cell_y_valid = 1'b0;
    if (bus.m_valid !== 1'b1) rtmo = 1'b1;
    if (bus.m_data !== rm || bus.m_last !== rlast) rstab = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    if (bus.m_valid !== 1'b0) rstab = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_step = 0; m_h = '0; m_c = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.s_ready, bus.m_valid, bus.cell_x_valid, bus.m_last, bus.err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.s_ready, bus.m_valid, bus.cell_x_valid, bus.m_last, bus.err});
    end
    n_checks++;
    if ({bus.cell_x, bus.cell_h, bus.cell_c, bus.m_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want all 0", bus.cell_x, bus.cell_h, bus.cell_c, bus.m_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_s_ready: got %b want 1", bus.s_ready);
    end
    m_step = 0; m_h = '0; m_c = '0;
  endtask

  task automatic test_single_step();
    bus.h_init = 16'h0100;
    bus.c_init = 16'h0080;
    run_step(16'h0040, 16'h0033, 16'h0055, 0, 2, 0, pulses, oh, oc, ox, om, olast, stable, tmo);
    n_checks++;
    if (tmo || oh !== 16'h0100 || oc !== 16'h0080 || ox !== 16'h0040) begin
      n_fail++;
      $display("FAIL single_issue: got h=%h c=%h x=%h tmo=%0d want 0100 0080 0040 0", oh, oc, ox, tmo);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL single_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (om !== 16'h0033 || olast !== 1'b0 || !stable) begin
      n_fail++;
      $display("FAIL single_result: got m=%h last=%b stable=%0d want 0033 0 1", om, olast, stable);
    end
    model_apply(16'h0033, 16'h0055);
  endtask

  task automatic test_wrap();
    run_step(16'h0011, 16'h0077, 16'h0066, 0, 1, 0, pulses, oh, oc, ox, om, olast, stable, tmo);
    n_checks++;
    if (tmo || oh !== 16'h0033 || oc !== 16'h0055) begin
      n_fail++;
      $display("FAIL wrap_recurrence: got h=%h c=%h tmo=%0d want 0033 0055 0", oh, oc, tmo);
    end
    n_checks++;
    if (om !== 16'h0077 || olast !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_last: got m=%h last=%b want 0077 1", om, olast);
    end
    n_checks++;
    if (bus.cell_h !== 16'h0100 || bus.cell_c !== 16'h0080) begin
      n_fail++;
      $display("FAIL wrap_reload: got h=%h c=%h want 0100 0080", bus.cell_h, bus.cell_c);
    end
    model_apply(16'h0077, 16'h0066);
    run_step(16'h0022, 16'h0044, 16'h0099, 0, 0, 0, pulses, oh, oc, ox, om, olast, stable, tmo);
    n_checks++;
    if (tmo || oh !== 16'h0100 || oc !== 16'h0080 || olast !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_restart: got h=%h c=%h last=%b want 0100 0080 0", oh, oc, olast);
    end
    model_apply(16'h0044, 16'h0099);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y, co, eh, ec;
    x = W'($urandom); y = W'($urandom); co = W'($urandom);
    eh = exp_h(); ec = exp_c();
    run_step(x, y, co, 0, 1, 10, pulses, oh, oc, ox, om, olast, stable, tmo);
    n_checks++;
    if (tmo || !stable || om !== y) begin
      n_fail++;
      $display("FAIL backpressure: got m=%h stable=%0d tmo=%0d want %h 1 0", om, stable, tmo, y);
    end
    n_checks++;
    if (oh !== eh || oc !== ec || olast !== (m_step == SL - 1)) begin
      n_fail++;
      $display("FAIL backpressure_state: got h=%h c=%h last=%b want %h %h %0d", oh, oc, olast, eh, ec, m_step == SL - 1);
    end
    model_apply(y, co);
  endtask

  task automatic test_cell_busy();
    logic [W-1:0] x, y, co;
    x = W'($urandom); y = W'($urandom); co = W'($urandom);
    run_step(x, y, co, 5, 2, 0, pulses, oh, oc, ox, om, olast, stable, tmo);
    n_checks++;
    if (tmo || pulses != 1 || !stable || ox !== x) begin
      n_fail++;
      $display("FAIL cell_busy: got pulses=%0d stable=%0d x=%h want 1 1 %h", pulses, stable, ox, x);
    end
    model_apply(y, co);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, co, eh, ec;
    bit           el;
    for (int k = 0; k < 30; k++) begin
      bus.h_init = W'($urandom);
      bus.c_init = W'($urandom);
      x = W'($urandom); y = W'($urandom); co = W'($urandom);
      eh = exp_h(); ec = exp_c(); el = (m_step == SL - 1);
      run_step(x, y, co, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), pulses, oh, oc, ox, om, olast, stable, tmo);
      n_checks++;
      if (tmo || oh !== eh || oc !== ec || ox !== x) begin
        n_fail++;
        $display("FAIL random_issue[%0d]: got h=%h c=%h x=%h want %h %h %h", k, oh, oc, ox, eh, ec, x);
      end
      n_checks++;
      if (om !== y || olast !== el || pulses != 1 || !stable) begin
        n_fail++;
        $display("FAIL random_result[%0d]: got m=%h last=%b pulses=%0d stable=%0d want %h %b 1 1",
                 k, om, olast, pulses, stable, y, el);
      end
      model_apply(y, co);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bus.cell_x_ready = 1'b1;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.s_data = W'($urandom); bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.s_ready, bus.m_valid, bus.cell_x_valid, bus.m_last, bus.err} !== 5'b0 ||
        {bus.cell_x, bus.cell_h, bus.cell_c, bus.m_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_wait_reset: got ctrl=%b data=%h/%h/%h/%h want all 0",
               {bus.s_ready, bus.m_valid, bus.cell_x_valid, bus.m_last, bus.err},
               bus.cell_x, bus.cell_h, bus.cell_c, bus.m_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait_release: got s_ready=%b want 1", bus.s_ready);
    end
    m_step = 0; m_h = '0; m_c = '0;
    bus.h_init = 16'h1234; bus.c_init = 16'h5678;
    run_step(16'h0001, 16'h0002, 16'h0003, 0, 0, 0, pulses, oh, oc, ox, om, olast, stable, tmo);
    n_checks++;
    if (tmo || oh !== 16'h1234 || oc !== 16'h5678 || olast !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_step0: got h=%h c=%h last=%b want 1234 5678 0", oh, oc, olast);
    end
    model_apply(16'h0002, 16'h0003);
  endtask

  task automatic test_watchdog();
    int n;
    bit early;
    bus.cell_x_ready = 1'b1;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.s_data = W'($urandom); bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
`ifdef LSTM_SEQ_WATCHDOG_EN
    early = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (bus.err !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL watchdog_early: got err=1 before %0d WAIT cycles want 0", TO);
    end
    @(negedge clk);
    n_checks++;
    if (bus.err !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_fire: got err=%b s_ready=%b want 1 0", bus.err, bus.s_ready);
    end
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.s_valid = 1'b1;
      @(negedge clk);
      if (bus.err !== 1'b1 || bus.s_ready !== 1'b0 || bus.cell_x_valid !== 1'b0) early = 1'b1;
    end
    bus.s_valid = 1'b0;
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL watchdog_sticky: got err/s_ready changed want err=1 s_ready=0");
    end
`else
    early = 1'b0;
    for (int i = 0; i < TO + 40; i++) begin
      @(negedge clk);
      if (bus.err !== 1'b0 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL no_watchdog: got err=%b m_valid=%b s_ready=%b want all 0 while waiting",
               bus.err, bus.m_valid, bus.s_ready);
    end
`endif
    do_reset();
    n_checks++;
    if (bus.err !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL watchdog_recover: got err=%b s_ready=%b want 0 1", bus.err, bus.s_ready);
    end
  endtask

  initial begin
    bus.s_data = '0; bus.s_valid = 1'b0;
    bus.h_init = '0; bus.c_init = '0;
    bus.cell_x_ready = 1'b1;
    bus.cell_y = '0; bus.cell_y_valid = 1'b0; bus.cell_c_out = '0;
    bus.m_ready = 1'b0;
    m_step = 0; m_h = '0; m_c = '0;
    test_reset();
    test_single_step();
    test_wrap();
    test_backpressure();
    test_cell_busy();
    test_random();
    test_reset_mid_wait();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion want finish within 500000 time units");
    $fatal(1);
  end

endmodule

// File: doc/lstm_sequencer.md
LSTM_SEQUENCER -- requirements
Module: lstm_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed fixed-point word width (8 fractional bits).
REQ-002 SHALL have parameter SEQ_LEN, default 8, number of time steps per sequence (range 2..255).
REQ-003 SHALL have parameter TIMEOUT, default 64, watchdog limit in cycles (used only when the watchdog is compiled in).
REQ-004 SHALL have ports, one per line:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  asynchronous, active-low reset
 s_data  in  WIDTH  upstream sample x[t]
 s_valid  in  1  upstream sample valid
 s_ready  out  1  sequencer accepts a sample
 h_init  in  WIDTH  short-term state loaded at sequence start
 c_init  in  WIDTH  long-term state loaded at sequence start
 cell_x  out  WIDTH  sample to cell x_in
 cell_h  out  WIDTH  recurrent h to cell h_in
 cell_c  out  WIDTH  recurrent C to cell C_in
 cell_x_valid  out  1  one-cycle issue pulse to cell
 cell_x_ready  in  1  cell idle
 cell_y  in  WIDTH  cell y_out
 cell_y_valid  in  1  cell result pulse
 cell_c_out  in  WIDTH  cell C_out, valid in the cycle cell_y_valid is high
 m_data  out  WIDTH  result h[t]
 m_valid  out  1  result valid
 m_ready  in  1  downstream accepts result
 m_last  out  1  result is final step of sequence
 err  out  1  sticky watchdog error

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, OUTPUT, plus ERROR when the watchdog is compiled in.
REQ-006 SHALL drive s_ready=1 only in IDLE; a sample is accepted on s_valid&&s_ready, latched into cell_x, and the FSM moves to ISSUE.
REQ-007 SHALL, in ISSUE, assert cell_x_valid for exactly one cycle when cell_x_ready=1, then move to WAIT; with cell_x_ready=0 it SHALL stay in ISSUE with cell_x_valid=0.
REQ-008 SHALL hold cell_x, cell_h, cell_c stable from ISSUE entry until the WAIT exit.
REQ-009 SHALL, in WAIT on cell_y_valid=1, register h<=cell_y, C<=cell_c_out, m_data<=cell_y, and move to OUTPUT; cell_y_valid outside WAIT SHALL be ignored.
REQ-010 SHALL assert m_valid throughout OUTPUT, holding m_data/m_last stable until m_valid&&m_ready, then return to IDLE on the following cycle.
REQ-011 SHALL keep a step counter 0..SEQ_LEN-1; m_last=1 when step==SEQ_LEN-1.
REQ-012 SHALL increment step on the output handshake; at SEQ_LEN-1 it SHALL wrap to 0 and reload h<=h_init, C<=c_init in the same cycle.
REQ-013 SHALL load h_init/c_init when a sample is accepted with step==0, overriding stored h/C, so the first step of every sequence uses the init values.
REQ-014 SHALL pass words unmodified, without width change or saturation; cell_h/cell_c are the h/C registers.
REQ-015 SHALL handle at most one sample in flight; minimum throughput is one result per (3 + cell latency + 1) cycles.
REQ-016 SHALL, when a handshake and a wrap occur in the same cycle, apply the wrap reload in preference to the REQ-009 update.

Reset
REQ-017 SHALL, on rst=0, asynchronously force FSM=IDLE, step=0, h=0, C=0, cell_x=0, m_data=0, cell_x_valid=0, m_valid=0, m_last=0, err=0, s_ready=0 while rst is low.
REQ-018 SHALL, after rst deasserts, raise s_ready on the first clk edge; a reset mid-sequence discards the in-flight sample and any pending result.

Configuration
REQ-019 SHALL compile a WAIT-state watchdog only when macro LSTM_SEQ_WATCHDOG_EN is defined: a counter cleared on WAIT entry; when it reaches TIMEOUT without cell_y_valid, the FSM SHALL enter ERROR, set err=1, and force s_ready=0 until reset.
REQ-020 SHALL, without LSTM_SEQ_WATCHDOG_EN, wait in WAIT indefinitely, tie err to 0, and contain no ERROR state or counter.

Verification
REQ-021 Reset: rst=0 mid-WAIT -> all outputs 0 immediately; after release, s_ready=1 and step=0.
REQ-022 Single step: SEQ_LEN=2, h_init=0x0100, c_init=0x0080, sample 0x0040 -> cell_h=0x0100, cell_c=0x0080, one cell_x_valid pulse; with cell_y=0x0033 -> m_data=0x0033, m_last=0.
REQ-023 Recurrence/wrap: second sample -> cell_h=0x0033 and cell_c=prior cell_c_out, m_last=1; third sample -> cell_h back to h_init.
REQ-024 Backpressure: m_ready=0 for 10 cycles -> m_valid/m_data stable and s_ready=0 throughout; result consumed on the first m_ready=1.
REQ-025 Cell busy: cell_x_ready=0 for 5 cycles in ISSUE -> no cell_x_valid until cell_x_ready=1, then exactly one pulse.
REQ-026 Watchdog (LSTM_SEQ_WATCHDOG_EN, TIMEOUT=64): no cell_y_valid -> err=1 after 64 WAIT cycles, s_ready=0 until reset; without the macro -> err stays 0.
